// File: rtl/wave_gen_pkg.sv
// Shared definitions for the waveform generator: waveform select codes,
// triangle FSM states and limits, LFSR seed/taps and its step function.
package wave_gen_pkg;

  typedef enum logic [2:0] {
    WS_SAW   = 3'b000,
    WS_SQR   = 3'b001,
    WS_TRI   = 3'b010,
    WS_SIN   = 3'b011,
    WS_NOISE = 3'b100
  } wsel_e;

  typedef enum logic {
    TRI_UP   = 1'b0,
    TRI_DOWN = 1'b1
  } tri_dir_e;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Feedback taps at bits 7, 5, 4, 3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  localparam logic signed [7:0] TRI_MAX  = 8'sd126;
  localparam logic signed [7:0] TRI_MIN  = 8'sh80;  // -128
  localparam logic signed [7:0] TRI_STEP = 8'sd2;

  // Fibonacci LFSR step: shift left, feedback is the XOR of the tapped bits.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sine_qlut.sv
// Quarter-wave sine ROM: mag = round(127*sin(2*pi*(idx+0.5)/256)).
// The half-step offset keeps the table symmetric, so the other three
// quadrants are produced by index mirroring and sign inversion alone.
module sine_qlut (
  input  logic [5:0] idx,
  output logic [6:0] mag
);

  localparam logic [6:0] LUT [64] = '{
      7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
      7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
      7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
      7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
      7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
      7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
      7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  assign mag = LUT[idx];

endmodule

// File: rtl/wave_gen.sv
// Programmable waveform source: prescaled sample ticks advance a phase
// counter, a triangle up/down FSM and an LFSR; a registered mux picks the
// waveform. sample_stb marks the first cycle a new sample is on out_wave.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [2:0]       wsel,
  output logic [7:0]       out_wave,
  output logic             sample_stb
);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        phase_q, phase_d;
  logic signed [7:0] tri_val_q, tri_val_d;
  tri_dir_e          dir_q, dir_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic              tick_dly_q, tick_dly_d;
  logic [7:0]        out_q, out_d;
  logic              stb_q, stb_d;

  logic              tick;
  logic [5:0]        sin_idx;
  logic [6:0]        sin_mag;

  // >= rather than == so that lowering div below the running count ticks
  // on the next cycle instead of wrapping the full counter range.
  assign tick = en && (cnt_q >= div);

  // Quadrants 1 and 3 read the table backwards; 63-x is ~x on 6 bits.
  assign sin_idx = phase_q[6] ? ~phase_q[5:0] : phase_q[5:0];

  sine_qlut u_sine_qlut (
    .idx (sin_idx),
    .mag (sin_mag)
  );

  // Generator next state: prescaler, phase, triangle FSM and LFSR.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    tri_val_d = tri_val_q;
    dir_d     = dir_q;
    lfsr_d    = lfsr_q;
    if (tick) begin
      cnt_d   = '0;
      phase_d = phase_q + 8'd1;
      lfsr_d  = lfsr_next(lfsr_q);
      case (dir_q)
        TRI_UP: begin
          if (tri_val_q == TRI_MAX) begin
            tri_val_d = TRI_MAX - TRI_STEP;
            dir_d     = TRI_DOWN;
          end else begin
            tri_val_d = tri_val_q + TRI_STEP;
          end
        end
        TRI_DOWN: begin
          if (tri_val_q == TRI_MIN) begin
            tri_val_d = TRI_MIN + TRI_STEP;
            dir_d     = TRI_UP;
          end else begin
            tri_val_d = tri_val_q - TRI_STEP;
          end
        end
      endcase
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output mux and strobe pipeline, re-evaluated every clock.
  always_comb begin
    tick_dly_d = tick;
    stb_d      = tick_dly_q;
    case (wsel)
      WS_SAW:   out_d = {~phase_q[7], phase_q[6:0]};
      WS_SQR:   out_d = phase_q[7] ? 8'h80 : 8'h7F;
      WS_TRI:   out_d = tri_val_q;
      WS_SIN:   out_d = phase_q[7] ? (8'd0 - {1'b0, sin_mag}) : {1'b0, sin_mag};
      WS_NOISE: out_d = lfsr_q;
      default:  out_d = 8'h00;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      phase_q    <= 8'd0;
      tri_val_q  <= TRI_MIN;
      dir_q      <= TRI_UP;
      lfsr_q     <= LFSR_SEED;
      tick_dly_q <= 1'b0;
      out_q      <= 8'h00;
      stb_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      tri_val_q  <= tri_val_d;
      dir_q      <= dir_d;
      lfsr_q     <= lfsr_d;
      tick_dly_q <= tick_dly_d;
      out_q      <= out_d;
      stb_q      <= stb_d;
    end
  end

  assign out_wave   = out_q;
  assign sample_stb = stb_q;

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen. The reference model counts sample ticks
// and derives each waveform directly from the tick count with arithmetic
// (and real-valued sin for the sine table).
module tb_wave_gen;

  localparam int  DIV_W = 8;
  localparam real PI    = 3.14159265358979323846;

  logic             clk  = 1'b0;
  logic             rst  = 1'b0;
  logic             en   = 1'b0;
  logic [DIV_W-1:0] div  = '0;
  logic [2:0]       wsel = 3'd0;
  logic [7:0]       out_wave;
  logic             sample_stb;

  wave_gen #(.DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div        (div),
    .wsel       (wsel),
    .out_wave   (out_wave),
    .sample_stb (sample_stb)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] sine_tab  [256];
  logic [7:0] noise_seq [255];

  // Reference model state: prescaler count, ticks since reset, strobe pipe.
  int         m_cnt;
  int         m_n;
  logic       m_tickd;
  logic [7:0] m_out;
  logic       m_stb;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Sample value after n ticks for a given waveform select.
  function automatic logic [7:0] wave(input logic [2:0] ws, input int n);
    int p;
    int t;
    p = n % 256;
    t = n % 254;
    case (ws)
      3'd0:    return 8'(p - 128);
      3'd1:    return (p < 128) ? 8'h7F : 8'h80;
      3'd2:    return (t <= 127) ? 8'(-128 + 2 * t) : 8'(-128 + 2 * (254 - t));
      3'd3:    return sine_tab[p];
      3'd4:    return noise_seq[n % 255];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_edge();
    logic tk;
    tk      = en && (m_cnt >= int'(div));
    m_out   = wave(wsel, m_n);
    m_stb   = m_tickd;
    m_tickd = tk;
    if (tk) begin
      m_cnt = 0;
      m_n++;
    end else if (en) begin
      m_cnt++;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "/out"}, out_wave, m_out);
    check({tag, "/stb"}, {7'd0, sample_stb}, {7'd0, m_stb});
  endtask

  // Assert reset away from the clock edge, confirm outputs clear at once,
  // hold through one edge, release just after the following edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check({tag, "/rst_out"}, out_wave, 8'h00);
    check({tag, "/rst_stb"}, {7'd0, sample_stb}, 8'h00);
    m_cnt   = 0;
    m_n     = 0;
    m_tickd = 1'b0;
    m_out   = 8'h00;
    m_stb   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] l;
    for (int p = 0; p < 256; p++) begin
      real r;
      r = 127.0 * $sin(2.0 * PI * (real'(p) + 0.5) / 256.0);
      sine_tab[p] = (r >= 0.0) ? 8'($rtoi(r + 0.5)) : 8'(-$rtoi(-r + 0.5));
    end
    l = 8'h01;
    for (int k = 0; k < 255; k++) begin
      noise_seq[k] = l;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end

    // Sawtooth, one tick per clock.
    en = 1'b1; div = 8'd0; wsel = 3'd0;
    do_reset("saw");
    step("saw");
    check("saw_first", out_wave, 8'h80);
    step("saw");
    check("saw_second", out_wave, 8'h81);
    check("saw_second_stb", {7'd0, sample_stb}, 8'h01);
    repeat (300) step("saw");

    // Square with a tick every 4 clocks.
    div = 8'd3; wsel = 3'd1;
    do_reset("sqr");
    repeat (4 * 260) step("sqr");

    // Triangle through more than two full periods.
    div = 8'd0; wsel = 3'd2;
    do_reset("tri");
    repeat (600) step("tri");

    // Sine over a full phase revolution.
    wsel = 3'd3;
    do_reset("sin");
    repeat (300) step("sin");

    // Noise: first samples after the seed, then beyond one full period.
    wsel = 3'd4;
    do_reset("noise");
    step("noise");
    step("noise");
    check("noise_1", out_wave, 8'h02);
    step("noise");
    check("noise_2", out_wave, 8'h04);
    step("noise");
    check("noise_3", out_wave, 8'h08);
    step("noise");
    check("noise_4", out_wave, 8'h11);
    repeat (520) step("noise");

    // Enable low: generator frozen, no strobes after the pipeline drains.
    en = 1'b0;
    repeat (10) step("en_off");
    check("en_off_stb", {7'd0, sample_stb}, 8'h00);
    wsel = 3'd0;
    step("en_off_wsel");
    en = 1'b1;

    // Lowering div below the running count ticks on the next clock.
    div = 8'd200; wsel = 3'd0;
    do_reset("div");
    for (int i = 0; i < 300 && m_cnt != 50; i++) step("div_pre");
    div = 8'd5;
    step("div_chg");
    step("div_chg");
    check("div_chg_stb", {7'd0, sample_stb}, 8'h01);
    repeat (40) step("div_post");

    // Randomized enable, divider and waveform select.
    for (int i = 0; i < 2000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) wsel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) div = 8'($urandom_range(0, 6));
      step("rand");
    end

    // Asynchronous reset while running at full rate.
    en = 1'b1; div = 8'd0; wsel = 3'd3;
    repeat (20) step("pre_rst");
    do_reset("mid");
    repeat (20) step("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
